// File: rtl/note_sequencer_if.sv
// Control and note bus between the sequencer and its controller.
// Controller drives transport/pattern inputs; sequencer drives note/gate.
interface note_sequencer_if;
  logic       START;
  logic       STOP;
  logic       LOOP;
  logic       PATTERN_SEL;
  logic [1:0] TEMPO_SEL;
  logic [1:0] NOTE_SEL;
  logic       GATE;
  logic [3:0] STEP_IDX;
  logic       STEP_STROBE;
  logic       BUSY;

  modport master (
    output START, STOP, LOOP, PATTERN_SEL, TEMPO_SEL,
    input  NOTE_SEL, GATE, STEP_IDX, STEP_STROBE, BUSY
  );

  modport slave (
    input  START, STOP, LOOP, PATTERN_SEL, TEMPO_SEL,
    output NOTE_SEL, GATE, STEP_IDX, STEP_STROBE, BUSY
  );
endinterface

// File: rtl/note_sequencer.sv
// 16-step note pattern player feeding the tone oscillator.
// Drives note select, articulation gate, step index and step strobe.
module note_sequencer #(
  parameter int BEAT_CYC = 2500,
  parameter int GAP_CYC  = 250,
  parameter int CNT_W    = 16
) (
  input  logic CLK,
  input  logic RST_N,
  note_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    NOTE,
    GAP
  } state_t;

  // Packed {step15 .. step0}, two bits per step.
  localparam logic [31:0] ROM0 = 32'h1BE4_1BE4;
  localparam logic [31:0] ROM1 = 32'h8D72_9CD8;
  localparam logic [CNT_W-1:0] GAP_W = CNT_W'(GAP_CYC);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic [3:0]       step_q, step_d;
  logic             pat_q, pat_d;
  logic [1:0]       note_q, note_d;
  logic             gate_q, gate_d;
  logic             strobe_q, strobe_d;
  logic             busy_q, busy_d;

  function automatic logic [1:0] rom(
    input logic       pat,
    input logic [3:0] idx
  );
    logic [31:0] tbl;
    tbl = pat ? ROM1 : ROM0;
    return tbl[{idx, 1'b0} +: 2];
  endfunction

  // Last counter value of a step for a given tempo.
  function automatic logic [CNT_W-1:0] last_of(
    input logic [1:0] tempo
  );
    return CNT_W'((BEAT_CYC << tempo) - 1);
  endfunction

  // Next-state: STOP beats START, START restarts from any state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    step_d   = step_q;
    pat_d    = pat_q;
    note_d   = note_q;
    gate_d   = gate_q;
    strobe_d = 1'b0;
    busy_d   = busy_q;
    if (bus.STOP) begin
      state_d = IDLE;
      gate_d  = 1'b0;
      busy_d  = 1'b0;
    end else if (bus.START) begin
      state_d  = NOTE;
      pat_d    = bus.PATTERN_SEL;
      last_d   = last_of(bus.TEMPO_SEL);
      step_d   = 4'd0;
      cnt_d    = '0;
      note_d   = rom(bus.PATTERN_SEL, 4'd0);
      gate_d   = 1'b1;
      strobe_d = 1'b1;
      busy_d   = 1'b1;
    end else begin
      unique case (state_q)
        NOTE: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == last_q - GAP_W) begin
            state_d = GAP;
            gate_d  = 1'b0;
          end
        end
        GAP: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == last_q) begin
            if (step_q != 4'd15 || bus.LOOP) begin
              state_d  = NOTE;
              step_d   = step_q + 4'd1;
              cnt_d    = '0;
              last_d   = last_of(bus.TEMPO_SEL);
              note_d   = rom(pat_q, step_q + 4'd1);
              gate_d   = 1'b1;
              strobe_d = 1'b1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= '0;
      step_q   <= 4'd0;
      pat_q    <= 1'b0;
      note_q   <= 2'd0;
      gate_q   <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      step_q   <= step_d;
      pat_q    <= pat_d;
      note_q   <= note_d;
      gate_q   <= gate_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.NOTE_SEL    = note_q;
  assign bus.GATE        = gate_q;
  assign bus.STEP_IDX    = step_q;
  assign bus.STEP_STROBE = strobe_q;
  assign bus.BUSY        = busy_q;

endmodule
